spi_byte_arbiter: RTL

- Shares one byte-level SPI master between NUM_REQ requesters.
- Requesters submit multi-byte transactions as byte streams with a last flag.
- The block grants the master round-robin and holds the grant for a whole transaction. It feeds bytes to the master one at a time and routes each received byte back to the granted requester.
- Sits between the protocol clients (flash, sensor and config engines) and the SPI master.

---
 rtl/spi_byte_arbiter_if.sv | 15 +
 rtl/spi_byte_arbiter.sv | 105 ++++++++++
 2 files changed

// File: rtl/spi_byte_arbiter_if.sv
// spi_byte_arbiter_if: requester-side and SPI-master-side signals of spi_byte_arbiter
interface spi_byte_arbiter_if #(parameter int NUM_REQ = 4);
  logic [NUM_REQ-1:0] req_valid, req_last, req_ready, rsp_valid, grant;
  logic [8*NUM_REQ-1:0] req_data;
  logic [7:0] rsp_data, m_tx_data, m_rx_data;
  logic rsp_last, rsp_err, m_tx_valid, m_tx_ready, m_rx_valid;
  modport master (
    output req_valid, req_data, req_last, m_tx_ready, m_rx_data, m_rx_valid,
    input  req_ready, rsp_valid, rsp_data, rsp_last, rsp_err, grant, m_tx_data, m_tx_valid
  );
  modport slave (
    input  req_valid, req_data, req_last, m_tx_ready, m_rx_data, m_rx_valid,
    output req_ready, rsp_valid, rsp_data, rsp_last, rsp_err, grant, m_tx_data, m_tx_valid
  );
endinterface

// File: rtl/spi_byte_arbiter.sv
// spi_byte_arbiter: round-robin sharing of one byte-level SPI master among NUM_REQ requesters
// Per-byte watchdog is compiled in only with SPI_ARB_TIMEOUT_EN.
module spi_byte_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic clk,
  input logic rst,
  spi_byte_arbiter_if.slave bus
);
  localparam int PW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state, state_d;
  logic [PW-1:0] rr, rr_d, own, own_d, win, idx;
  logic last_flag, last_d, expire, done;
  logic [NUM_REQ-1:0] grant_d, req_ready_d, rsp_valid_d;
  logic [7:0] rsp_data_d, tx_data_d;
  logic rsp_last_d, rsp_err_d, tx_valid_d;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= state == WAIT ? cnt + TW'(1) : '0;
  assign expire = state == WAIT && cnt == TW'(TIMEOUT_CYCLES - 1) && !bus.m_rx_valid;
`else
  assign expire = 1'b0;
`endif
  assign done = bus.m_rx_valid || expire;
  // Descending scan so the nearest requester after the pointer is written last and wins.
  always_comb begin
    win = rr;
    idx = rr;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = PW'((int'(rr) + k) % NUM_REQ);
      if (bus.req_valid[idx]) win = idx;
    end
  end
  always_comb begin
    state_d = state;
    rr_d = rr;
    own_d = own;
    last_d = last_flag;
    grant_d = bus.grant;
    req_ready_d = '0;
    rsp_valid_d = '0;
    tx_valid_d = 1'b0;
    tx_data_d = bus.m_tx_data;
    rsp_data_d = bus.rsp_data;
    rsp_last_d = 1'b0;
    rsp_err_d = 1'b0;
    case (state)
      IDLE: if (|bus.req_valid) begin
        state_d = ISSUE;
        own_d = win;
        grant_d = NUM_REQ'(1) << win;
      end
      ISSUE: if (bus.req_valid[own] && bus.m_tx_ready) begin
        state_d = WAIT;
        tx_valid_d = 1'b1;
        req_ready_d[own] = 1'b1;
        tx_data_d = bus.req_data[{own, 3'b000} +: 8];
        last_d = bus.req_last[own];
      end
      WAIT: if (done) begin
        rsp_valid_d[own] = 1'b1;
        rsp_data_d = expire ? 8'h00 : bus.m_rx_data;
        rsp_last_d = last_flag || expire;
        rsp_err_d = expire;
        state_d = last_flag || expire ? IDLE : ISSUE;
        rr_d = last_flag || expire ? own : rr;
        grant_d = last_flag || expire ? '0 : bus.grant;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      rr <= PW'(NUM_REQ - 1);
      own <= '0;
      last_flag <= 1'b0;
      bus.grant <= '0;
      bus.req_ready <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_data <= '0;
      bus.rsp_last <= 1'b0;
      bus.rsp_err <= 1'b0;
      bus.m_tx_data <= '0;
      bus.m_tx_valid <= 1'b0;
    end else begin
      state <= state_d;
      rr <= rr_d;
      own <= own_d;
      last_flag <= last_d;
      bus.grant <= grant_d;
      bus.req_ready <= req_ready_d;
      bus.rsp_valid <= rsp_valid_d;
      bus.rsp_data <= rsp_data_d;
      bus.rsp_last <= rsp_last_d;
      bus.rsp_err <= rsp_err_d;
      bus.m_tx_data <= tx_data_d;
      bus.m_tx_valid <= tx_valid_d;
    end
endmodule
